// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: Ethernet transmit framer for a 25 MHz, 4-bit-per-cycle RMII path.
// Each mii_clk cycle carries one nibble: mii_Q[1:0] is the first dibit on the wire, [3:2] the
// second. The external ODDRs serialise it. A frame is made of a 7-byte 0x55 preamble, an SFD
// (0xD5), the payload, optional zero padding, a 4-byte CRC-32 FCS and an inter-frame gap.
//
// Build option: define RMII_TX_PAD_EN to compile in the PAD state. PAD zero-fills short
// payloads up to MIN_LEN bytes. Without the macro, DATA always goes straight to FCS.
//
// Parameters:
//   IFG_CYCLES  inter-frame gap in mii_clk cycles (24 = 12 byte times), minimum 2
//   MIN_LEN     minimum payload byte count before the FCS (padding build only)
// Ports:
//   mii_clk   only clock, 25 MHz
//   rst_n     asynchronous active-low reset
//   tx_data   payload byte
//   tx_valid  payload byte available
//   tx_last   tx_data is the final byte of the frame
//   tx_ready  byte is taken when tx_valid && tx_ready
//   mii_Q     transmit nibble, low nibble of each byte first, LSB first
//   mii_QV    transmit enable
//   busy      high in every state except IDLE
//   underrun  one-cycle pulse when the payload source fails to deliver a byte
module rmii_tx_framer #(
  parameter int unsigned IFG_CYCLES = 24,
  parameter int unsigned MIN_LEN    = 60
) (
  input  logic       mii_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [3:0] mii_Q,
  output logic       mii_QV,
  output logic       busy,
  output logic       underrun
);

  // The padding counter is 11 bits wide, so larger minimum lengths cannot be honoured.
  if (MIN_LEN > 2047) begin : gen_min_len_chk
    $error("MIN_LEN must not exceed 2047");
  end

  // The IDLE cycle that samples tx_valid is the final gap cycle. IFG therefore lasts one cycle
  // less than IFG_CYCLES.
  localparam logic [15:0] IfgLast = (IFG_CYCLES < 2) ? 16'd0 : 16'(IFG_CYCLES - 2);

`ifdef RMII_TX_PAD_EN
  localparam logic [10:0] MinLen = 11'(MIN_LEN);

  typedef enum logic [2:0] {
    StIdle, StPre, StSfd, StData, StPad, StFcs, StIfg
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StPre, StSfd, StData, StFcs, StIfg
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;        // cycle index within the current state
  logic [31:0] crc_q, crc_d;
  logic [3:0]  hi_q, hi_d;          // high nibble of the byte in flight
  logic        last_q, last_d;
  logic        bad_q, bad_d;        // frame underran: send the corrupted FCS
  logic [3:0]  q_q, q_d;
  logic        qv_q, qv_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;
`ifdef RMII_TX_PAD_EN
  logic [10:0] bcnt_q, bcnt_d;      // payload + pad bytes, saturating
`endif

  logic accept;       // this cycle's tx_ready slot is resolved
  logic end_payload;  // last payload or pad byte finished its high nibble

  // Reflected CRC-32 (0xEDB88320), four bits per call, LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      c = (c[0] ^ nib[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // The *_d values describe the cycle after the next edge. State and every output register
  // update together, so the wire always matches state_q.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    hi_d        = hi_q;
    last_d      = last_q;
    bad_d       = bad_q;
    q_d         = 4'h0;
    qv_d        = 1'b1;
    ready_d     = 1'b0;
    underrun_d  = 1'b0;
    accept      = 1'b0;
    end_payload = 1'b0;
`ifdef RMII_TX_PAD_EN
    bcnt_d      = bcnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        qv_d = 1'b0;
        if (tx_valid) begin
          state_d = StPre;
          cnt_d   = 16'd0;
          qv_d    = 1'b1;
          q_d     = 4'h5;
        end
      end
      StPre: begin
        q_d   = 4'h5;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd13) begin
          state_d = StSfd;
          cnt_d   = 16'd0;
          crc_d   = 32'hFFFF_FFFF;
          bad_d   = 1'b0;
`ifdef RMII_TX_PAD_EN
          bcnt_d  = 11'd0;
`endif
        end
      end
      StSfd: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = 16'd1;
          q_d     = 4'hD;
          ready_d = 1'b1;
        end else begin
          accept = 1'b1;
        end
      end
      StData: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = 16'd1;
          q_d     = hi_q;
          crc_d   = crc_nib(crc_q, hi_q);
          ready_d = !last_q;
        end else if (last_q) begin
          end_payload = 1'b1;
        end else begin
          accept = 1'b1;
        end
      end
`ifdef RMII_TX_PAD_EN
      StPad: begin
        if (cnt_q == 16'd0) begin
          cnt_d = 16'd1;
          crc_d = crc_nib(crc_q, 4'h0);
        end else begin
          end_payload = 1'b1;
        end
      end
`endif
      StFcs: begin
        q_d   = bad_q ? crc_q[3:0] : ~crc_q[3:0];
        crc_d = {4'h0, crc_q[31:4]};
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd7) begin
          state_d = StIfg;
          cnt_d   = 16'd0;
          qv_d    = 1'b0;
          q_d     = 4'h0;
        end
      end
      StIfg: begin
        qv_d  = 1'b0;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q >= IfgLast) begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = StIdle;
        qv_d    = 1'b0;
      end
    endcase

    // tx_ready was high this cycle: take the byte, or abort the frame with a bad FCS.
    if (accept) begin
      cnt_d = 16'd0;
      if (tx_valid) begin
        state_d = StData;
        q_d     = tx_data[3:0];
        hi_d    = tx_data[7:4];
        last_d  = tx_last;
        crc_d   = crc_nib(crc_q, tx_data[3:0]);
`ifdef RMII_TX_PAD_EN
        bcnt_d  = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
`endif
      end else begin
        state_d    = StFcs;
        underrun_d = 1'b1;
        bad_d      = 1'b1;
        q_d        = crc_q[3:0];
        crc_d      = {4'h0, crc_q[31:4]};
      end
    end

    if (end_payload) begin
      state_d = StFcs;
      cnt_d   = 16'd0;
      q_d     = ~crc_q[3:0];
      crc_d   = {4'h0, crc_q[31:4]};
`ifdef RMII_TX_PAD_EN
      if (bcnt_q < MinLen) begin
        state_d = StPad;
        q_d     = 4'h0;
        crc_d   = crc_nib(crc_q, 4'h0);
        bcnt_d  = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
      end
`endif
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge mii_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      crc_q      <= 32'hFFFF_FFFF;
      hi_q       <= 4'h0;
      last_q     <= 1'b0;
      bad_q      <= 1'b0;
      q_q        <= 4'h0;
      qv_q       <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef RMII_TX_PAD_EN
      bcnt_q     <= 11'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      hi_q       <= hi_d;
      last_q     <= last_d;
      bad_q      <= bad_d;
      q_q        <= q_d;
      qv_q       <= qv_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
`ifdef RMII_TX_PAD_EN
      bcnt_q     <= bcnt_d;
`endif
    end
  end

  assign tx_ready = ready_q;
  assign mii_Q    = q_q;
  assign mii_QV   = qv_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_rmii_tx_framer.sv
// Testbench for rmii_tx_framer. Expected wire bytes go into a scoreboard queue as each frame is
// driven. The recorded mii_Q stream is then split into frames and compared byte by byte.
module tb_rmii_tx_framer;

  localparam int unsigned IfgCycles = 24;
  localparam int unsigned MinLen    = 60;
`ifdef RMII_TX_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif

  logic       mii_clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [3:0] mii_Q;
  logic       mii_QV;
  logic       busy;
  logic       underrun;

  rmii_tx_framer #(
    .IFG_CYCLES(IfgCycles),
    .MIN_LEN   (MinLen)
  ) dut (
    .mii_clk (mii_clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_last (tx_last),
    .tx_ready(tx_ready),
    .mii_Q   (mii_Q),
    .mii_QV  (mii_QV),
    .busy    (busy),
    .underrun(underrun)
  );

  always #20 mii_clk = ~mii_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] payload_q[$];
  logic [7:0] frame_q[$];
  logic [3:0] rec_q[$];
  logic       rec_v[$];
  logic       rec_r[$];
  logic       rec_u[$];
  logic       rec_b[$];
  int         hi_len[$];
  int         gap_len[$];
  int         trail_low, n_frames, n_underrun, n_q_nonzero, n_ifg_ready, n_pre5;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  function automatic int elen(input int n, input int drop);
    if (drop >= 0) return drop;
    if (PadEn && n < int'(MinLen)) return int'(MinLen);
    return n;
  endfunction

  // Waits for a tx_ready slot, then steps just past the edge that consumes it.
  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge mii_clk);
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("tx_ready timeout", 32'(tx_ready), 32'd1);
    @(posedge mii_clk);
    #1;
  endtask

  // drop >= 0 withholds that payload byte, which forces an underrun.
  task automatic drive_frame(input int drop);
    logic [31:0] crc;
    int          n;
    crc = 32'hFFFF_FFFF;
    n   = 0;
    for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < payload_q.size(); i++) begin
      if (i == drop) begin
        tx_valid = 1'b0;
        wait_ready();
        break;
      end
      tx_valid = 1'b1;
      tx_data  = payload_q[i];
      tx_last  = (i == payload_q.size() - 1);
      wait_ready();
      exp_q.push_back(payload_q[i]);
      crc = crc_byte(crc, payload_q[i]);
      n++;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    if (drop < 0) begin
      while (n < elen(n, -1)) begin
        exp_q.push_back(8'h00);
        crc = crc_byte(crc, 8'h00);
        n++;
      end
      crc = ~crc;
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
  endtask

  task automatic record(input int ncyc);
    rec_q.delete(); rec_v.delete(); rec_r.delete(); rec_u.delete(); rec_b.delete();
    repeat (ncyc) begin
      @(negedge mii_clk);
      rec_q.push_back(mii_Q);
      rec_v.push_back(mii_QV);
      rec_r.push_back(tx_ready);
      rec_u.push_back(underrun);
      rec_b.push_back(busy);
    end
  endtask

  // Splits the recording into frames and pops the scoreboard for every byte seen.
  task automatic analyze(input string tag);
    int         low_run, hi, nib, bidx, first;
    bit         in_frame;
    logic [3:0] lo;
    logic [7:0] b, e;
    frame_q.delete(); hi_len.delete(); gap_len.delete();
    n_frames = 0; n_underrun = 0; n_q_nonzero = 0; n_ifg_ready = 0; n_pre5 = 0;
    low_run = 0; hi = 0; nib = 0; bidx = 0; in_frame = 1'b0; lo = 4'h0; first = -1;
    for (int i = 0; i < rec_v.size(); i++) begin
      if (rec_u[i]) n_underrun++;
      if (!rec_v[i] && rec_q[i] != 4'h0) n_q_nonzero++;
      if (!rec_v[i] && rec_b[i] && rec_r[i]) n_ifg_ready++;
      if (rec_v[i]) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          hi = 0;
          nib = 0;
          if (n_frames > 0) gap_len.push_back(low_run);
          frame_q.delete();
          if (first < 0) first = i;
        end
        if (first >= 0 && i < first + 14 && rec_q[i] == 4'h5) n_pre5++;
        hi++;
        if (nib[0] == 1'b0) begin
          lo = rec_q[i];
        end else begin
          b = {rec_q[i], lo};
          frame_q.push_back(b);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          check($sformatf("%s byte %0d", tag, bidx), 32'(b), 32'(e));
          bidx++;
        end
        nib++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          hi_len.push_back(hi);
          n_frames++;
          low_run = 0;
        end
        low_run++;
      end
    end
    trail_low = low_run;
    check({tag, " leftover expected"}, 32'(exp_q.size()), 32'd0);
    check({tag, " mii_Q zero while idle"}, 32'(n_q_nonzero), 32'd0);
    exp_q.delete();
  endtask

  function automatic logic [31:0] residue();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < frame_q.size(); i++) c = crc_byte(c, frame_q[i]);
    return c;
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, c;
    bit hit;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    repeat (3) @(posedge mii_clk);
    #1;
    check("reset mii_QV", 32'(mii_QV), 32'd0);
    check("reset mii_Q", 32'(mii_Q), 32'd0);
    check("reset tx_ready", 32'(tx_ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    @(negedge mii_clk);
    rst_n = 1'b1;

    // "123456789" back-to-back.
    payload_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fork
      drive_frame(-1);
      record(300);
    join
    analyze("t1");
    check("t1 frames", 32'(n_frames), 32'd1);
    check("t1 qv high cycles", 32'(hi_len[0]), 32'(2 * (8 + elen(9, -1) + 4)));
    check("t1 ifg low >= 24", 32'(trail_low >= 24), 32'd1);
    check("t1 residue", residue(), 32'hDEBB_20E3);
    check("t1 underrun", 32'(n_underrun), 32'd0);
`ifndef RMII_TX_PAD_EN
    check("t1 fcs0", 32'(frame_q[17]), 32'h26);
    check("t1 fcs1", 32'(frame_q[18]), 32'h39);
    check("t1 fcs2", 32'(frame_q[19]), 32'hF4);
    check("t1 fcs3", 32'(frame_q[20]), 32'hCB);
`endif

    // Single byte payload: padded only in the padding build.
    payload_q = '{8'hAB};
    fork
      drive_frame(-1);
      record(300);
    join
    analyze("t2");
    check("t2 frames", 32'(n_frames), 32'd1);
    check("t2 frame bytes", 32'(frame_q.size()), 32'(8 + elen(1, -1) + 4));
    check("t2 residue", residue(), 32'hDEBB_20E3);

    // Underrun at payload byte 5 of 64.
    payload_q.delete();
    for (int i = 0; i < 64; i++) payload_q.push_back(8'($urandom_range(0, 255)));
    fork
      drive_frame(4);
      record(200);
    join
    analyze("t3");
    check("t3 underrun pulses", 32'(n_underrun), 32'd1);
    check("t3 frame bytes", 32'(frame_q.size()), 32'd16);
    check("t3 qv high cycles", 32'(hi_len[0]), 32'd32);
    check("t3 ifg low >= 24", 32'(trail_low >= 24), 32'd1);

    // Reset in the third FCS cycle.
    payload_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    target = 16 + 2 * elen(9, -1) + 3;
    fork
      drive_frame(-1);
      begin
        c = 0;
        hit = 1'b0;
        for (int k = 0; k < 400; k++) begin
          @(negedge mii_clk);
          if (mii_QV) c++;
          if (c == target) begin
            hit = 1'b1;
            break;
          end
        end
        check("t4 reached fcs", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4 async mii_QV", 32'(mii_QV), 32'd0);
        check("t4 async mii_Q", 32'(mii_Q), 32'd0);
        check("t4 async busy", 32'(busy), 32'd0);
      end
    join
    exp_q.delete();
    repeat (2) @(posedge mii_clk);
    @(negedge mii_clk);
    rst_n = 1'b1;
    fork
      drive_frame(-1);
      record(300);
    join
    analyze("t4");
    check("t4 frames", 32'(n_frames), 32'd1);
    check("t4 preamble nibbles", 32'(n_pre5), 32'd14);

    // Two frames queued back-to-back.
    fork
      begin
        payload_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hA9,
                      8'hBA, 8'hCB};
        drive_frame(-1);
        payload_q = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69};
        drive_frame(-1);
      end
      record(500);
    join
    analyze("t5");
    check("t5 frames", 32'(n_frames), 32'd2);
    check("t5 gap cycles", 32'(gap_len[0]), 32'd24);
    check("t5 tx_ready in ifg", 32'(n_ifg_ready), 32'd0);
    check("t5 frame2 qv high", 32'(hi_len[1]), 32'(2 * (8 + elen(10, -1) + 4)));
    check("t5 residue", residue(), 32'hDEBB_20E3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
